// File: rtl/io_port_memory_if.sv
// Processor data-memory bus plus the handshaked input/output port bundle of io_port_memory.
// master drives the bus and the port producers/consumers; slave is the memory itself.
interface io_port_memory_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned NUM_IN     = 2,
   parameter int unsigned NUM_OUT    = 2
);
   logic                          IO_write;
   logic                          IO_read;
   logic [ADDR_WIDTH-1:0]         IO_address;
   logic [DATA_WIDTH-1:0]         IO_data_in;
   logic [DATA_WIDTH-1:0]         IO_data_out;
   logic [NUM_IN*DATA_WIDTH-1:0]  in_data;
   logic [NUM_IN-1:0]             in_valid;
   logic [NUM_IN-1:0]             in_ready;
   logic [NUM_OUT*DATA_WIDTH-1:0] out_data;
   logic [NUM_OUT-1:0]            out_valid;
   logic [NUM_OUT-1:0]            out_ack;

   modport master (
      output IO_write, IO_read, IO_address, IO_data_in, in_data, in_valid, out_ack,
      input  IO_data_out, in_ready, out_data, out_valid
   );

   modport slave (
      input  IO_write, IO_read, IO_address, IO_data_in, in_data, in_valid, out_ack,
      output IO_data_out, in_ready, out_data, out_valid
   );
endinterface

// File: rtl/io_port_memory.sv
// Data memory with a RAM window and a memory-mapped bank of handshaked input/output ports
// plus a status register; registered read data, read-before-write on the same address.
module io_port_memory #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned NUM_IN     = 2,
   parameter int unsigned NUM_OUT    = 2,
   parameter int unsigned IO_BASE    = 'hff0
) (
   input logic         clock,
   input logic         reset_n,
   io_port_memory_if.slave bus
);
   localparam int unsigned MemAw    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned OutBase  = IO_BASE + NUM_IN;
   localparam int unsigned StatAddr = IO_BASE + NUM_IN + NUM_OUT;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [DATA_WIDTH-1:0] in_reg_q  [NUM_IN];
   logic [DATA_WIDTH-1:0] in_reg_d  [NUM_IN];
   logic [DATA_WIDTH-1:0] out_reg_q [NUM_OUT];
   logic [DATA_WIDTH-1:0] out_reg_d [NUM_OUT];
   logic [NUM_IN-1:0]     in_full_q, in_full_d;
   logic [NUM_OUT-1:0]    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] status;

   logic [31:0]           addr;
   logic [MemAw-1:0]      mem_idx;
   logic                  mem_hit;
   logic                  stat_hit;
   logic [NUM_IN-1:0]     in_hit;
   logic [NUM_OUT-1:0]    out_hit;

   assign addr    = 32'(bus.IO_address);
   assign mem_idx = bus.IO_address[MemAw-1:0];

   always_comb begin
      mem_hit  = addr < MEM_DEPTH;
      stat_hit = addr == StatAddr;
      for (int i = 0; i < NUM_IN; i++) begin
         in_hit[i] = addr == IO_BASE + 32'(i);
      end
      for (int j = 0; j < NUM_OUT; j++) begin
         out_hit[j] = addr == OutBase + 32'(j);
      end
   end

   always_comb begin
      status                    = '0;
      status[NUM_IN-1:0]        = in_full_q;
      status[NUM_IN +: NUM_OUT] = out_valid_q;
   end

   // Unmapped addresses fall through to zero.
   always_comb begin
      rdata_d = '0;
      if (mem_hit) begin
         rdata_d = mem[mem_idx];
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_hit[i]) begin
            rdata_d = in_reg_q[i];
         end
      end
      for (int j = 0; j < NUM_OUT; j++) begin
         if (out_hit[j]) begin
            rdata_d = out_reg_q[j];
         end
      end
      if (stat_hit) begin
         rdata_d = status;
      end
   end

   // Capture needs in_full=0 and read-clear needs in_full=1, so they are exclusive per port.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_reg_d[i]  = in_reg_q[i];
         in_full_d[i] = in_full_q[i];
         if (bus.in_valid[i] && !in_full_q[i]) begin
            in_reg_d[i]  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_full_d[i] = 1'b1;
         end else if (bus.IO_read && in_hit[i]) begin
            in_full_d[i] = 1'b0;
         end
      end
   end

   // A processor write beats a same-edge acknowledge.
   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         out_reg_d[j]   = out_reg_q[j];
         out_valid_d[j] = out_valid_q[j];
         if (bus.IO_write && out_hit[j]) begin
            out_reg_d[j]   = bus.IO_data_in;
            out_valid_d[j] = 1'b1;
         end else if (bus.out_ack[j]) begin
            out_valid_d[j] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q     <= '0;
         in_full_q   <= '0;
         out_valid_q <= '0;
         in_reg_q    <= '{default: '0};
         out_reg_q   <= '{default: '0};
      end else begin
         rdata_q     <= rdata_d;
         in_full_q   <= in_full_d;
         out_valid_q <= out_valid_d;
         in_reg_q    <= in_reg_d;
         out_reg_q   <= out_reg_d;
      end
   end

   always_ff @(posedge clock) begin
      if (bus.IO_write && mem_hit) begin
         mem[mem_idx] <= bus.IO_data_in;
      end
   end

   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         bus.out_data[j*DATA_WIDTH +: DATA_WIDTH] = out_reg_q[j];
      end
   end

   assign bus.IO_data_out = rdata_q;
   assign bus.in_ready    = ~in_full_q;
   assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_io_port_memory.sv
// Self-checking bench for io_port_memory: directed scenarios then randomized traffic,
// compared each cycle against an address-map level reference model.
module tb_io_port_memory;
   localparam int DW    = 16;
   localparam int AW    = 12;
   localparam int DEPTH = 256;
   localparam int NI    = 2;
   localparam int NO    = 2;
   localparam int BASE  = 'hff0;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   io_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

   io_port_memory #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (DEPTH),
      .NUM_IN    (NI),
      .NUM_OUT   (NO),
      .IO_BASE   (BASE)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_in  [NI];
   logic [DW-1:0] m_out [NO];
   bit            m_full [NI];
   bit            m_ov   [NO];
   logic [DW-1:0] m_rd;
   int tests = 0;
   int fails = 0;

   function automatic logic [DW-1:0] model_read(input int a);
      logic [DW-1:0] st;
      if (a < DEPTH) return m_mem[a];
      if (a >= BASE && a < BASE + NI) return m_in[a - BASE];
      if (a >= BASE + NI && a < BASE + NI + NO) return m_out[a - BASE - NI];
      if (a == BASE + NI + NO) begin
         st = '0;
         for (int i = 0; i < NI; i++) if (m_full[i]) st = st + DW'(1 << i);
         for (int j = 0; j < NO; j++) if (m_ov[j]) st = st + DW'(1 << (NI + j));
         return st;
      end
      return '0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [NI-1:0]    er;
      logic [NO-1:0]    ev;
      logic [NO*DW-1:0] ed;
      for (int i = 0; i < NI; i++) er[i] = !m_full[i];
      for (int j = 0; j < NO; j++) begin
         ev[j]            = m_ov[j];
         ed[j*DW +: DW]   = m_out[j];
      end
      check("IO_data_out", 64'(bus.IO_data_out), 64'(m_rd));
      check("in_ready", 64'(bus.in_ready), 64'(er));
      check("out_valid", 64'(bus.out_valid), 64'(ev));
      check("out_data", 64'(bus.out_data), 64'(ed));
   endtask

   task automatic bus_op(input bit wr, input bit rd, input int a, input logic [DW-1:0] d);
      bus.IO_write   = wr;
      bus.IO_read    = rd;
      bus.IO_address = AW'(a);
      bus.IO_data_in = d;
   endtask

   // Inputs are only changed after this returns, so they still hold the sampled values here.
   task automatic cycle();
      int a;
      @(posedge clock);
      #1;
      a    = int'(bus.IO_address);
      m_rd = model_read(a);
      if (bus.IO_write && a < DEPTH) m_mem[a] = bus.IO_data_in;
      for (int i = 0; i < NI; i++) begin
         if (bus.in_valid[i] && !m_full[i]) begin
            m_in[i]   = bus.in_data[i*DW +: DW];
            m_full[i] = 1'b1;
         end else if (bus.IO_read && a == BASE + i && m_full[i]) begin
            m_full[i] = 1'b0;
         end
      end
      for (int j = 0; j < NO; j++) begin
         if (bus.IO_write && a == BASE + NI + j) begin
            m_out[j] = bus.IO_data_in;
            m_ov[j]  = 1'b1;
         end else if (bus.out_ack[j]) begin
            m_ov[j] = 1'b0;
         end
      end
      check_outputs();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      m_rd = '0;
      for (int i = 0; i < NI; i++) begin m_in[i] = '0; m_full[i] = 1'b0; end
      for (int j = 0; j < NO; j++) begin m_out[j] = '0; m_ov[j] = 1'b0; end
      check("rst_data_out", 64'(bus.IO_data_out), 64'h0);
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_in_ready", 64'(bus.in_ready), 64'h3);
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   function automatic int rand_addr();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, DEPTH - 1));
         1:       return BASE + int'($urandom_range(0, NI + NO + 1));
         2:       return int'($urandom_range(DEPTH, (1 << AW) - 1));
         default: return BASE + int'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      bus_op(0, 0, 0, '0);
      bus.in_data  = '0;
      bus.in_valid = '0;
      bus.out_ack  = '0;
      m_rd = '0;
      #12;
      do_reset();

      for (int a = 0; a < DEPTH; a++) begin
         bus_op(1, 0, a, DW'($urandom));
         cycle();
      end

      bus_op(1, 0, 'h00a, 16'h3169); cycle();
      bus_op(0, 1, 'h00a, '0);       cycle();
      check("rd_00a", 64'(bus.IO_data_out), 64'h3169);
      bus_op(0, 1, 'h100, '0);       cycle();
      check("rd_unmapped", 64'(bus.IO_data_out), 64'h0);

      bus_op(0, 0, 'h100, '0);
      bus.in_valid = 2'b01;
      bus.in_data[15:0] = 16'h3131;
      cycle();
      check("in_ready0_low", 64'(bus.in_ready[0]), 64'h0);
      bus.in_valid = 2'b00;
      bus_op(0, 0, 'hff4, '0);       cycle();
      check("status_full0", 64'(bus.IO_data_out), 64'h0001);
      bus.in_valid = 2'b01;
      bus.in_data[15:0] = 16'h4242;
      bus_op(0, 0, 'h100, '0);       cycle();
      check("in_held", 64'(bus.in_ready[0]), 64'h0);
      bus_op(0, 1, 'hff0, '0);       cycle();
      check("in_read_3131", 64'(bus.IO_data_out), 64'h3131);
      check("in_ready0_high", 64'(bus.in_ready[0]), 64'h1);
      bus_op(0, 0, 'h100, '0);       cycle();
      bus.in_valid = 2'b00;
      bus_op(0, 1, 'hff0, '0);       cycle();
      check("in_read_4242", 64'(bus.IO_data_out), 64'h4242);

      bus_op(1, 0, 'hff2, 16'h3170); cycle();
      check("out0_valid", 64'(bus.out_valid[0]), 64'h1);
      check("out0_data", 64'(bus.out_data[15:0]), 64'h3170);
      bus_op(0, 0, 'hff4, '0);       cycle();
      check("status_bit2", 64'(bus.IO_data_out[2]), 64'h1);
      bus.out_ack = 2'b01;
      bus_op(0, 0, 'h100, '0);       cycle();
      check("out0_acked", 64'(bus.out_valid[0]), 64'h0);
      bus.out_ack = 2'b00;
      bus_op(0, 1, 'hff2, '0);       cycle();
      check("out0_readback", 64'(bus.IO_data_out), 64'h3170);

      bus_op(1, 0, 'hff3, 16'h0abc); cycle();
      bus.out_ack = 2'b10;
      bus_op(1, 0, 'hff3, 16'h5555); cycle();
      check("out1_write_wins", 64'(bus.out_valid[1]), 64'h1);
      check("out1_data", 64'(bus.out_data[31:16]), 64'h5555);
      bus.out_ack = 2'b00;

      bus.in_valid = 2'b01;
      bus.in_data[15:0] = 16'h7777;
      bus_op(0, 0, 'h100, '0);       cycle();
      bus.in_valid = 2'b00;
      bus_op(0, 0, 'hff0, '0);       cycle();
      bus_op(0, 0, 'hff0, '0);       cycle();
      check("peek_data", 64'(bus.IO_data_out), 64'h7777);
      check("peek_keeps_full", 64'(bus.in_ready[0]), 64'h0);
      bus_op(1, 0, 'hff0, 16'hffff); cycle();
      bus_op(1, 0, 'hff4, 16'hffff); cycle();
      bus_op(0, 0, 'hff0, '0);       cycle();
      check("ro_write_ignored", 64'(bus.IO_data_out), 64'h7777);

      bus_op(1, 0, 'h003, 16'h0007); cycle();
      bus_op(1, 1, 'h003, 16'h1234); cycle();
      check("rbw_old", 64'(bus.IO_data_out), 64'h0007);
      bus_op(0, 1, 'h003, '0);       cycle();
      check("rbw_new", 64'(bus.IO_data_out), 64'h1234);

      do_reset();

      for (int k = 0; k < 1500; k++) begin
         if (k == 750) do_reset();
         bus_op($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rand_addr(), DW'($urandom));
         bus.in_valid = NI'($urandom);
         bus.in_data  = (NI*DW)'({$urandom, $urandom});
         bus.out_ack  = NO'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/io_port_memory.md
# io_port_memory

Parametrised data/IO memory for the processor: a synchronous RAM window plus a memory-mapped bank of NUM_IN handshaked input ports, NUM_OUT handshaked output ports and one status register. It sits on the processor data-memory bus (IO_address / IO_data_in / IO_data_out / IO_write) and replaces the single fixed processor_input/processor_output pair with per-port valid/ready/ack flow control.

## Interface
- DATA_WIDTH, 16, bus and port data width
- ADDR_WIDTH, 12, bus address width
- MEM_DEPTH, 256, RAM words; RAM occupies addresses 0..MEM_DEPTH-1
- NUM_IN, 2, input ports (1..8)
- NUM_OUT, 2, output ports (1..8); NUM_IN+NUM_OUT <= DATA_WIDTH
- IO_BASE, 12'hff0, first IO address; MEM_DEPTH <= IO_BASE; IO_BASE+NUM_IN+NUM_OUT < 2^ADDR_WIDTH
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- IO_write  in  1  write strobe, sampled at clock edge
- IO_read  in  1  read strobe; qualifies read side effects only
- IO_address  in  ADDR_WIDTH  word address
- IO_data_in  in  DATA_WIDTH  write data
- IO_data_out  out  DATA_WIDTH  registered read data
- in_data  in  NUM_IN*DATA_WIDTH  packed input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_IN  producer has data
- in_ready  out  NUM_IN  port can accept (= ~in_full[i])
- out_data  out  NUM_OUT*DATA_WIDTH  packed output registers
- out_valid  out  NUM_OUT  output register holds unacknowledged data
- out_ack  in  NUM_OUT  consumer accepts out_data[j]

## Operation
- Address map: A < MEM_DEPTH: RAM. A = IO_BASE+i (i<NUM_IN): input data reg i, read-only. A = IO_BASE+NUM_IN+j: output reg j, read/write. A = IO_BASE+NUM_IN+NUM_OUT: STATUS, read-only. All other addresses: read 0, writes ignored.
- STATUS bits: [i] = in_full[i]; [NUM_IN+j] = out_valid[j]; upper bits 0.
- Input port i: per-port flag in_full. When in_valid[i] & in_ready[i] at an edge, in_reg[i] <= in_data slice, in_full[i] <= 1. Processor read (IO_read=1, A=IO_BASE+i) with in_full=1 clears in_full. Read with in_full=0 returns last in_reg value, no side effect. in_ready is registered-state based, so capture and read-clear never coincide on the same port.
- Output port j: IO_write to its address loads out_reg[j] and sets out_valid[j]. out_ack[j] with out_valid[j]=1 clears out_valid. Same-edge write and ack: write wins, out_valid stays 1, out_data holds new value. Writes while out_valid=1 overwrite (no stall).
- Writes to input-data or STATUS addresses ignored. IO_read=0 reads return data without side effects.
- Reset: IO_data_out=0, in_reg=0, in_full=0 (in_ready all 1), out_reg=0, out_valid=0. RAM contents not reset. Reset asserted mid-operation clears all flags immediately; pending captures/writes lost.

## Timing
- Read latency 1 cycle: IO_data_out updated at the edge sampling IO_address; every cycle loads the addressed value regardless of IO_read.
- Write takes effect at the sampling edge; a read of the same address in the next cycle returns the new value. Same-edge read and write of one address returns old value (read-before-write).
- in_ready falls the cycle after a capture; rises the cycle after the clearing read.
- out_valid rises the cycle after the write; falls the cycle after out_ack.
- STATUS read reflects flags as of the sampling edge (pre-update).

## Test plan
- Reset, then write 16'h3169 to 12'h00a, read 12'h00a -> IO_data_out=16'h3169 one cycle after address; read 12'h100 -> 0; reset mid-run -> IO_data_out, out_valid, in_full all 0 immediately.
- Drive in_valid[0]=1, in_data[0]=16'h3131 -> in_ready[0] low next cycle, STATUS(12'hff4)=16'h0001; IO_read at 12'hff0 -> 16'h3131, in_ready[0] high after; second 16'h4242 offered while full is held until read.
- Write 16'h3170 to 12'hff2 -> out_data[0]=16'h3170, out_valid[0]=1, STATUS bit2=1; out_ack[0] -> out_valid[0]=0; readback 12'hff2 -> 16'h3170.
- Same-edge write 16'h5555 to 12'hff3 and out_ack[1]=1 with out_valid[1]=1 -> out_valid[1] stays 1, out_data[1]=16'h5555.
- Read 12'hff0 with IO_read=0 while full -> data returned, in_full stays 1; write 16'hffff to 12'hff0 and 12'hff4 -> no change.
- Same-edge write 16'h1234 and read of 12'h003 holding 16'h0007 -> returns 16'h0007, next read 16'h1234.
